// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle RISC-V main controller.
// States, ALU operation codes, opcodes and datapath mux encodings live here.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMREAD,
        MEMWB,
        MEMWRITE,
        EXECUTER,
        EXECUTEI,
        ALUWB,
        BRANCH,
        JAL,
        LUI,
        ILLEGAL
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD,
        ALUOP_FUNCT,
        ALUOP_BRANCH
    } aluop_t;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_XOR  = 4'b0110;
    localparam logic [3:0] ALU_SRL  = 4'b0111;
    localparam logic [3:0] ALU_SLTU = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1111;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RS2    = 2'b00;
    localparam logic [1:0] SRCB_IMM    = 2'b01;
    localparam logic [1:0] SRCB_FOUR   = 2'b10;

    // Immediate format depends only on the opcode; unknown opcodes fall back to I.
    function automatic logic [2:0] imm_src_of(input logic [6:0] op);
        case (op)
            OP_STORE:  return IMM_S;
            OP_BRANCH: return IMM_B;
            OP_JAL:    return IMM_J;
            OP_LUI:    return IMM_U;
            default:   return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/mc_alu_decoder.sv
// ALU decoder: turns the operation class plus funct fields into ALUControl.
// MC_CTRL_EXT_BRANCH_EN adds bne/blt/bge/bltu/bgeu; otherwise only beq is legal.
import mc_ctrl_pkg::*;

module mc_alu_decoder (
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       is_r,
    input  aluop_t     alu_op,
    output logic [3:0] alu_control,
    output logic       taken_on_zero,
    output logic       branch_legal
);

    logic [3:0] br_control;
    logic       br_on_zero;
    logic [3:0] funct_control;

    always_comb begin
        br_control   = ALU_SUB;
        br_on_zero   = 1'b1;
        branch_legal = 1'b0;
`ifdef MC_CTRL_EXT_BRANCH_EN
        case (funct3)
            3'b000: begin br_control = ALU_SUB;  br_on_zero = 1'b1; branch_legal = 1'b1; end
            3'b001: begin br_control = ALU_SUB;  br_on_zero = 1'b0; branch_legal = 1'b1; end
            3'b100: begin br_control = ALU_SLT;  br_on_zero = 1'b0; branch_legal = 1'b1; end
            3'b101: begin br_control = ALU_SLT;  br_on_zero = 1'b1; branch_legal = 1'b1; end
            3'b110: begin br_control = ALU_SLTU; br_on_zero = 1'b0; branch_legal = 1'b1; end
            3'b111: begin br_control = ALU_SLTU; br_on_zero = 1'b1; branch_legal = 1'b1; end
            default: ;
        endcase
`else
        branch_legal = (funct3 == 3'b000);
`endif
    end

    // funct7b5 selects sub only for R-type; for shifts it selects sra in both R and I.
    always_comb begin
        case (funct3)
            3'b000:  funct_control = (is_r && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  funct_control = ALU_SLL;
            3'b010:  funct_control = ALU_SLT;
            3'b011:  funct_control = ALU_SLTU;
            3'b100:  funct_control = ALU_XOR;
            3'b101:  funct_control = funct7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  funct_control = ALU_OR;
            default: funct_control = ALU_AND;
        endcase
    end

    always_comb begin
        alu_control   = ALU_ADD;
        taken_on_zero = 1'b1;
        case (alu_op)
            ALUOP_FUNCT:  alu_control = funct_control;
            ALUOP_BRANCH: begin
                alu_control   = br_control;
                taken_on_zero = br_on_zero;
            end
            default:      alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle RISC-V main controller: Moore FSM driving datapath muxes and enables.
// Extended branches are enabled by defining MC_CTRL_EXT_BRANCH_EN.
import mc_ctrl_pkg::*;

module mc_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ImmSrc,
    output logic [3:0] ALUControl,
    output logic       IllegalInstr
);

    state_t     state_q, state_d;
    aluop_t     alu_op;
    logic       is_r;
    logic [3:0] dec_alu_control;
    logic       dec_taken_on_zero;
    logic       dec_branch_legal;

    mc_alu_decoder u_alu_decoder (
        .funct3        (funct3),
        .funct7b5      (funct7b5),
        .is_r          (is_r),
        .alu_op        (alu_op),
        .alu_control   (dec_alu_control),
        .taken_on_zero (dec_taken_on_zero),
        .branch_legal  (dec_branch_legal)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:  state_d = DECODE;
            DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: state_d = MEMADR;
                    OP_RTYPE:          state_d = EXECUTER;
                    OP_ITYPE:          state_d = EXECUTEI;
                    OP_BRANCH:         state_d = dec_branch_legal ? BRANCH : ILLEGAL;
                    OP_JAL:            state_d = JAL;
                    OP_LUI:            state_d = LUI;
                    default:           state_d = ILLEGAL;
                endcase
            end
            MEMADR:   state_d = (op == OP_STORE) ? MEMWRITE : MEMREAD;
            MEMREAD:  state_d = MEMWB;
            MEMWB:    state_d = FETCH;
            MEMWRITE: state_d = FETCH;
            EXECUTER: state_d = ALUWB;
            EXECUTEI: state_d = ALUWB;
            ALUWB:    state_d = FETCH;
            BRANCH:   state_d = FETCH;
            JAL:      state_d = ALUWB;
            LUI:      state_d = ALUWB;
            ILLEGAL:  state_d = ILLEGAL;
            default:  state_d = FETCH;
        endcase
    end

    // Operation class fed to the ALU decoder, kept apart from the output block.
    always_comb begin
        alu_op = ALUOP_ADD;
        is_r   = (state_q == EXECUTER);
        case (state_q)
            EXECUTER, EXECUTEI: alu_op = ALUOP_FUNCT;
            BRANCH:             alu_op = ALUOP_BRANCH;
            default:            alu_op = ALUOP_ADD;
        endcase
    end

    always_comb begin
        PCWrite      = 1'b0;
        AdrSrc       = 1'b0;
        MemWrite     = 1'b0;
        IRWrite      = 1'b0;
        RegWrite     = 1'b0;
        ResultSrc    = RES_ALUOUT;
        ALUSrcA      = SRCA_PC;
        ALUSrcB      = SRCB_RS2;
        ImmSrc       = IMM_I;
        ALUControl   = ALU_ADD;
        IllegalInstr = 1'b0;
        if (!reset) begin
            ImmSrc     = imm_src_of(op);
            ALUControl = dec_alu_control;
            case (state_q)
                FETCH: begin
                    IRWrite   = 1'b1;
                    PCWrite   = 1'b1;
                    ALUSrcB   = SRCB_FOUR;
                    ResultSrc = RES_ALURESULT;
                end
                DECODE: begin
                    ALUSrcA = SRCA_OLDPC;
                    ALUSrcB = SRCB_IMM;
                end
                MEMADR, EXECUTEI: begin
                    ALUSrcA = SRCA_RS1;
                    ALUSrcB = SRCB_IMM;
                end
                MEMREAD:  AdrSrc = 1'b1;
                MEMWB: begin
                    ResultSrc = RES_DATA;
                    RegWrite  = 1'b1;
                end
                MEMWRITE: begin
                    AdrSrc   = 1'b1;
                    MemWrite = 1'b1;
                end
                EXECUTER: ALUSrcA = SRCA_RS1;
                ALUWB:    RegWrite = 1'b1;
                BRANCH: begin
                    ALUSrcA = SRCA_RS1;
                    PCWrite = dec_taken_on_zero ? Zero : !Zero;
                end
                JAL: begin
                    ALUSrcA = SRCA_OLDPC;
                    ALUSrcB = SRCB_FOUR;
                    PCWrite = 1'b1;
                end
                LUI: begin
                    ALUSrcA = SRCA_ZERO;
                    ALUSrcB = SRCB_IMM;
                end
                ILLEGAL:  IllegalInstr = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_controller.sv
// Randomized self-checking bench for mc_controller against an instruction-level model.
// Follows MC_CTRL_EXT_BRANCH_EN the same way the design does.
module tb_mc_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, IllegalInstr;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
    logic [2:0] ImmSrc;
    logic [3:0] ALUControl;

    int n_checks = 0;
    int n_fail   = 0;

    mc_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
        .ALUControl(ALUControl), .IllegalInstr(IllegalInstr)
    );

    always #5 clk = ~clk;

    wire [18:0] dut_vec = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                           ALUSrcA, ALUSrcB, ImmSrc, ALUControl, IllegalInstr};

    typedef enum int {ST_F, ST_D, ST_MA, ST_MR, ST_MWB, ST_MW, ST_XR, ST_XI,
                      ST_WB, ST_BR, ST_J, ST_L, ST_ILL} step_e;

    step_e plan[$];

    localparam logic [3:0] FTAB [8] = '{4'h0, 4'h4, 4'h5, 4'h8, 4'h6, 4'h7, 4'h3, 4'h2};

    function automatic logic [2:0] imm_model(input logic [6:0] o);
        if (o == 7'b0100011) return 3'd1;
        if (o == 7'b1100011) return 3'd2;
        if (o == 7'b1101111) return 3'd3;
        if (o == 7'b0110111) return 3'd4;
        return 3'd0;
    endfunction

    function automatic logic [3:0] funct_model(input logic [2:0] f3, input logic b5, input logic r);
        if (f3 == 3'd0 && r && b5) return 4'h1;
        if (f3 == 3'd5 && b5)      return 4'hF;
        return FTAB[f3];
    endfunction

    function automatic bit br_legal(input logic [2:0] f3);
`ifdef MC_CTRL_EXT_BRANCH_EN
        return !(f3 == 3'd2 || f3 == 3'd3);
`else
        return f3 == 3'd0;
`endif
    endfunction

    function automatic logic [3:0] br_alu(input logic [2:0] f3);
`ifdef MC_CTRL_EXT_BRANCH_EN
        if (f3[2]) return f3[1] ? 4'h8 : 4'h5;
`endif
        return 4'h1;
    endfunction

    function automatic logic br_taken(input logic [2:0] f3, input logic z);
`ifdef MC_CTRL_EXT_BRANCH_EN
        return (f3[0] ^ f3[2]) ? !z : z;
`else
        return z;
`endif
    endfunction

    function automatic logic [18:0] model_out(input step_e s, input logic [6:0] o,
                                              input logic [2:0] f3, input logic b5, input logic z);
        logic pcw = 0, adr = 0, memw = 0, irw = 0, regw = 0, ill = 0;
        logic [1:0] rs = 0, sa = 0, sb = 0;
        logic [3:0] alu = 0;
        case (s)
            ST_F:   begin irw = 1; pcw = 1; sb = 2; rs = 2; end
            ST_D:   begin sa = 1; sb = 1; end
            ST_MA:  begin sa = 2; sb = 1; end
            ST_MR:  adr = 1;
            ST_MWB: begin rs = 1; regw = 1; end
            ST_MW:  begin adr = 1; memw = 1; end
            ST_XR:  begin sa = 2; alu = funct_model(f3, b5, 1'b1); end
            ST_XI:  begin sa = 2; sb = 1; alu = funct_model(f3, b5, 1'b0); end
            ST_WB:  regw = 1;
            ST_BR:  begin sa = 2; alu = br_alu(f3); pcw = br_taken(f3, z); end
            ST_J:   begin sa = 1; sb = 2; pcw = 1; end
            ST_L:   begin sa = 3; sb = 1; end
            default: ill = 1;
        endcase
        return {pcw, adr, memw, irw, regw, rs, sa, sb, imm_model(o), alu, ill};
    endfunction

    task automatic build_plan(input logic [6:0] o, input logic [2:0] f3);
        plan.delete();
        plan.push_back(ST_F);
        plan.push_back(ST_D);
        case (o)
            7'b0000011: begin plan.push_back(ST_MA); plan.push_back(ST_MR); plan.push_back(ST_MWB); end
            7'b0100011: begin plan.push_back(ST_MA); plan.push_back(ST_MW); end
            7'b0110011: begin plan.push_back(ST_XR); plan.push_back(ST_WB); end
            7'b0010011: begin plan.push_back(ST_XI); plan.push_back(ST_WB); end
            7'b1101111: begin plan.push_back(ST_J);  plan.push_back(ST_WB); end
            7'b0110111: begin plan.push_back(ST_L);  plan.push_back(ST_WB); end
            7'b1100011: if (br_legal(f3)) plan.push_back(ST_BR);
                        else for (int i = 0; i < 20; i++) plan.push_back(ST_ILL);
            default:    for (int i = 0; i < 20; i++) plan.push_back(ST_ILL);
        endcase
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Entered just after a rising edge; leaves just after a rising edge with reset low.
    task automatic do_reset(input int n);
        reset = 1'b1;
        for (int i = 0; i < n; i++) begin
            op = 7'($urandom); funct3 = 3'($urandom); funct7b5 = 1'($urandom); Zero = 1'($urandom);
            @(negedge clk);
            check("reset_outputs", 32'(dut_vec), 32'd0);
            @(posedge clk); #1;
        end
        reset = 1'b0;
    endtask

    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic b5,
                             input int zmode, input bit pin_en, input int pin_alu,
                             input int pin_pcw, input int abort_at);
        logic z;
        build_plan(o, f3);
        op = o; funct3 = f3; funct7b5 = b5;
        $display("instr op=%b funct3=%b b5=%b cycles=%0d%s", o, f3, b5, plan.size(),
                 (abort_at >= 0) ? " (reset mid-instruction)" : "");
        for (int i = 0; i < plan.size(); i++) begin
            if (i == abort_at) begin
                do_reset(2);
                return;
            end
            z = (zmode < 0) ? 1'($urandom) : zmode[0];
            Zero = z;
            @(negedge clk);
            check($sformatf("outputs step%0d op=%b f3=%b", i, o, f3), 32'(dut_vec),
                  32'(model_out(plan[i], o, f3, b5, z)));
            if (pin_en) begin
                case (plan[i])
                    ST_F: begin
                        check("fetch_irwrite", 32'(IRWrite), 32'd1);
                        check("fetch_pcwrite", 32'(PCWrite), 32'd1);
                        check("fetch_alucontrol", 32'(ALUControl), 32'd0);
                    end
                    ST_MWB: check("memwb_regwrite_resultsrc", 32'({RegWrite, ResultSrc}), 32'b101);
                    ST_XR, ST_XI: if (pin_alu >= 0) check("exec_alucontrol", 32'(ALUControl), pin_alu);
                    ST_BR: begin
                        if (pin_alu >= 0) check("branch_alucontrol", 32'(ALUControl), pin_alu);
                        if (pin_pcw >= 0) check("branch_pcwrite", 32'(PCWrite), pin_pcw);
                    end
                    ST_ILL: check("illegal_flags", 32'({IllegalInstr, MemWrite, RegWrite}), 32'b100);
                    default: ;
                endcase
            end
            @(posedge clk); #1;
        end
        if (plan[plan.size()-1] == ST_ILL) do_reset(2);
    endtask

    initial begin
        logic [6:0] o;
        int k;
        reset = 1'b1; op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0; Zero = 1'b0;
        @(posedge clk); #1;
        do_reset(3);

        run_instr(7'b0000011, 3'b010, 1'b0, -1, 1'b1, -1, -1, -1);
        run_instr(7'b0110011, 3'b000, 1'b1, -1, 1'b1, 4'h1, -1, -1);
        run_instr(7'b0110011, 3'b101, 1'b1, -1, 1'b1, 4'hF, -1, -1);
        run_instr(7'b0010011, 3'b000, 1'b1, -1, 1'b1, 4'h0, -1, -1);
        run_instr(7'b1100011, 3'b000, 1'b0,  1, 1'b1, 4'h1, 1, -1);
        run_instr(7'b1100011, 3'b000, 1'b0,  0, 1'b1, 4'h1, 0, -1);
        run_instr(7'b1100011, 3'b111, 1'b0,  1, 1'b1, 4'h8, 1, -1);
        run_instr(7'b1111111, 3'b000, 1'b0, -1, 1'b1, -1, -1, -1);
        run_instr(7'b0100011, 3'b010, 1'b0, -1, 1'b1, -1, -1, -1);
        run_instr(7'b1101111, 3'b000, 1'b0, -1, 1'b1, -1, -1, -1);
        run_instr(7'b0110111, 3'b000, 1'b0, -1, 1'b1, -1, -1, -1);
        run_instr(7'b0000011, 3'b010, 1'b0, -1, 1'b1, -1, -1, 3);

        for (int n = 0; n < 300; n++) begin
            k = $urandom_range(0, 15);
            case (k)
                0, 1:    o = 7'b0000011;
                2:       o = 7'b0100011;
                3, 4, 5: o = 7'b0110011;
                6, 7, 8: o = 7'b0010011;
                9, 10, 11: o = 7'b1100011;
                12:      o = 7'b1101111;
                13:      o = 7'b0110111;
                default: begin
                    o = 7'($urandom);
                    while (o == 7'b0000011 || o == 7'b0100011 || o == 7'b0110011 ||
                           o == 7'b0010011 || o == 7'b1100011 || o == 7'b1101111 ||
                           o == 7'b0110111)
                        o = 7'($urandom);
                end
            endcase
            run_instr(o, 3'($urandom), 1'($urandom), -1, 1'b0, -1, -1,
                      ($urandom_range(0, 19) == 0) ? $urandom_range(1, 3) : -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
